// File: rtl/bus_map_pkg.sv
// Memory-map constants shared by the CPU bus wait controller and the address decoder.
// Region codes live in address bits [18:16]; bit 19 selects flash.
package bus_map_pkg;

  localparam logic [2:0] REGION_RAM      = 3'd0;
  localparam logic [2:0] REGION_VDP      = 3'd1;
  localparam logic [2:0] REGION_STATUS   = 3'd2;
  localparam logic [2:0] REGION_DSP      = 3'd3;
  localparam logic [2:0] REGION_PAD      = 3'd4;
  localparam logic [2:0] REGION_COP      = 3'd5;
  localparam logic [2:0] REGION_BOOT     = 3'd6;
  localparam logic [2:0] REGION_UNMAPPED = 3'd7;
  localparam int         FLASH_BIT       = 19;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_FLASH = 2'd2,
    ST_DONE  = 2'd3
  } bus_state_e;

  // Table entry 7 is unused (unmapped region faults instead of waiting).
  function automatic logic [3:0] region_wait(input logic [2:0] region,
                                             input logic [7:0][3:0] waits);
    return (region == REGION_UNMAPPED) ? 4'd0 : waits[region];
  endfunction

endpackage

// File: rtl/bus_timeout_counter.sv
// Cycle counter bounding WAIT/FLASH residency; expired_o flags the cycle that
// reaches TIMEOUT_CYCLES so the controller can force completion on that edge.
module bus_timeout_counter
  import bus_map_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int W = $clog2(TIMEOUT_CYCLES + 1);

  logic [W-1:0] cnt_q;

  assign expired_o = enable_i && (cnt_q == W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset || clear_i)
      cnt_q <= '0;
    else if (enable_i && cnt_q != W'(TIMEOUT_CYCLES))
      cnt_q <= cnt_q + 1'b1;
  end

endmodule

// File: rtl/bus_wait_controller.sv
// Generates cpu_mem_ready for every CPU bus access: per-region wait states,
// flash read handshake, timeout, and a sticky fault flag with latched address.
module bus_wait_controller
  import bus_map_pkg::*;
#(
  parameter int RAM_WAIT       = 0,
  parameter int VDP_WAIT       = 1,
  parameter int STATUS_WAIT    = 0,
  parameter int DSP_WAIT       = 1,
  parameter int PAD_WAIT       = 0,
  parameter int COP_WAIT       = 0,
  parameter int BOOT_WAIT      = 0,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_mem_valid,
  input  logic [19:0] cpu_address,
  input  logic [3:0]  cpu_wstrb,
  input  logic        flash_read_ready,
  input  logic        bus_fault_ack,
  output logic        cpu_mem_ready,
  output logic        busy,
  output logic        bus_fault,
  output logic [19:0] fault_address
);

  localparam logic [7:0][3:0] WAITS = {4'd0, 4'(BOOT_WAIT), 4'(COP_WAIT), 4'(PAD_WAIT),
                                       4'(DSP_WAIT), 4'(STATUS_WAIT), 4'(VDP_WAIT),
                                       4'(RAM_WAIT)};

  bus_state_e  state_q, state_d;
  logic [3:0]  wcnt_q, wcnt_d;
  logic [19:0] addr_q, addr_d;
  logic        ready_q;
  logic        fault_q, fault_d;
  logic [19:0] fault_addr_q, fault_addr_d;
  logic        fault_set;
  logic        expired;
  logic [3:0]  wait_n;
  logic        in_wait;

  assign wait_n  = region_wait(cpu_address[18:16], WAITS);
  assign in_wait = (state_q == ST_WAIT) || (state_q == ST_FLASH);

  bus_timeout_counter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk      (clk),
    .reset    (reset),
    .clear_i  (!in_wait),
    .enable_i (in_wait),
    .expired_o(expired)
  );

  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    addr_d    = addr_q;
    fault_set = 1'b0;
    unique case (state_q)
      ST_IDLE: if (cpu_mem_valid) begin
        addr_d = cpu_address;
        if (cpu_address[FLASH_BIT]) begin
          if (|cpu_wstrb) begin
            fault_set = 1'b1;
            state_d   = ST_DONE;
          end else begin
            state_d = ST_FLASH;
          end
        end else if (cpu_address[18:16] == REGION_UNMAPPED) begin
          fault_set = 1'b1;
          state_d   = ST_DONE;
        end else if (wait_n == 4'd0) begin
          state_d = ST_DONE;
        end else begin
          wcnt_d  = wait_n;
          state_d = ST_WAIT;
        end
      end
      // A dropped valid abandons the access silently; normal completion beats timeout.
      ST_WAIT: begin
        wcnt_d = wcnt_q - 4'd1;
        if (!cpu_mem_valid)    state_d = ST_IDLE;
        else if (wcnt_q == 4'd1) state_d = ST_DONE;
        else if (expired) begin
          fault_set = 1'b1;
          state_d   = ST_DONE;
        end
      end
      ST_FLASH: begin
        if (!cpu_mem_valid)        state_d = ST_IDLE;
        else if (flash_read_ready) state_d = ST_DONE;
        else if (expired) begin
          fault_set = 1'b1;
          state_d   = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // New fault outranks a same-cycle acknowledge.
  always_comb begin
    fault_d      = fault_q;
    fault_addr_d = fault_addr_q;
    if (fault_set) begin
      fault_d      = 1'b1;
      fault_addr_d = addr_d;
    end else if (bus_fault_ack) begin
      fault_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      wcnt_q       <= '0;
      addr_q       <= '0;
      ready_q      <= 1'b0;
      fault_q      <= 1'b0;
      fault_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      wcnt_q       <= wcnt_d;
      addr_q       <= addr_d;
      ready_q      <= (state_d == ST_DONE);
      fault_q      <= fault_d;
      fault_addr_q <= fault_addr_d;
    end
  end

  assign cpu_mem_ready = ready_q;
  assign busy          = (state_q != ST_IDLE);
  assign bus_fault     = fault_q;
  assign fault_address = fault_addr_q;

endmodule

// File: tb/tb_bus_wait_controller.sv
// Directed bench for bus_wait_controller: vector table of single accesses plus
// hand-written sequences for ack/fault collision, reset mid-wait, valid drop, back-to-back.
module tb_bus_wait_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_mem_valid;
  logic [19:0] cpu_address;
  logic [3:0]  cpu_wstrb;
  logic        flash_read_ready;
  logic        bus_fault_ack;
  logic        cpu_mem_ready;
  logic        busy;
  logic        bus_fault;
  logic [19:0] fault_address;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bus_wait_controller #(
    .RAM_WAIT(0), .VDP_WAIT(3), .STATUS_WAIT(0), .DSP_WAIT(5),
    .PAD_WAIT(0), .COP_WAIT(0), .BOOT_WAIT(0), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .reset(reset), .cpu_mem_valid(cpu_mem_valid), .cpu_address(cpu_address),
    .cpu_wstrb(cpu_wstrb), .flash_read_ready(flash_read_ready), .bus_fault_ack(bus_fault_ack),
    .cpu_mem_ready(cpu_mem_ready), .busy(busy), .bus_fault(bus_fault),
    .fault_address(fault_address)
  );

  // fdly: nonzero = pulse flash_read_ready so it is sampled on edge fdly+1 (edge 1 = accept).
  // lat: edge count, accept edge included, until ready is seen.
  typedef struct {
    logic [19:0] addr;
    logic [3:0]  wstrb;
    int          fdly;
    int          lat;
    logic        fault;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic access(input vec_t v, input int idx);
    int lat;
    bit got, busy_ok;
    @(negedge clk);
    cpu_mem_valid = 1'b1; cpu_address = v.addr; cpu_wstrb = v.wstrb;
    lat = 0; got = 0; busy_ok = 1;
    for (int i = 0; i < 100 && !got; i++) begin
      @(posedge clk); lat++;
      @(negedge clk); flash_read_ready = 1'b0;
      if (!busy) busy_ok = 0;
      if (cpu_mem_ready) got = 1;
      else if (v.fdly != 0 && lat == v.fdly) flash_read_ready = 1'b1;
    end
    cpu_mem_valid = 1'b0; flash_read_ready = 1'b0;
    chk($sformatf("v%0d latency", idx), got ? lat : -1, v.lat);
    chk($sformatf("v%0d busy", idx), 32'(busy_ok), 1);
    chk($sformatf("v%0d fault", idx), 32'(bus_fault), 32'(v.fault));
    if (v.fault) chk($sformatf("v%0d fault_addr", idx), 32'(fault_address), 32'(v.addr));
    @(negedge clk);
    chk($sformatf("v%0d ready_1cyc_idle", idx), {busy, cpu_mem_ready}, 0);
    if (bus_fault) begin
      bus_fault_ack = 1'b1;
      @(negedge clk);
      bus_fault_ack = 1'b0;
      chk($sformatf("v%0d ack_clear", idx), 32'(bus_fault), 0);
    end
  endtask

  initial begin
    bit seen;
    logic [2:0] pat;

    vecs[0]  = '{20'h00010, 4'h0, 0,  1, 1'b0};  // RAM read, 0 waits
    vecs[1]  = '{20'h10000, 4'hF, 0,  4, 1'b0};  // VDP write, 3 waits
    vecs[2]  = '{20'h20008, 4'h0, 0,  1, 1'b0};  // status
    vecs[3]  = '{20'h30000, 4'h0, 0,  6, 1'b0};  // DSP, 5 waits
    vecs[4]  = '{20'h40000, 4'h1, 0,  1, 1'b0};  // pad write
    vecs[5]  = '{20'h50004, 4'h0, 0,  1, 1'b0};  // copper
    vecs[6]  = '{20'h6FFFC, 4'h0, 0,  1, 1'b0};  // boot
    vecs[7]  = '{20'h70004, 4'h0, 0,  1, 1'b1};  // unmapped
    vecs[8]  = '{20'h80000, 4'h2, 0,  1, 1'b1};  // flash write
    vecs[9]  = '{20'h80000, 4'h0, 6,  7, 1'b0};  // flash read, late pulse
    vecs[10] = '{20'hFABCD, 4'h0, 1,  2, 1'b0};  // flash read, prompt pulse
    vecs[11] = '{20'h81234, 4'h0, 0, 17, 1'b1};  // flash timeout

    reset = 1'b1; cpu_mem_valid = 1'b0; cpu_address = '0; cpu_wstrb = '0;
    flash_read_ready = 1'b0; bus_fault_ack = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst ready", 32'(cpu_mem_ready), 0);
    chk("rst busy", 32'(busy), 0);
    chk("rst fault", 32'(bus_fault), 0);
    chk("rst fault_addr", 32'(fault_address), 0);
    reset = 1'b0;

    for (int i = 0; i < 12; i++) access(vecs[i], i);

    // Ack and new fault on the same edge: fault wins, address updates.
    @(negedge clk); cpu_mem_valid = 1'b1; cpu_address = 20'h70004; cpu_wstrb = 4'h0;
    @(negedge clk); cpu_mem_valid = 1'b0;
    @(negedge clk);
    chk("pre fault", 32'(bus_fault), 1);
    cpu_mem_valid = 1'b1; cpu_address = 20'h7FFFC; bus_fault_ack = 1'b1;
    @(negedge clk); cpu_mem_valid = 1'b0; bus_fault_ack = 1'b0;
    chk("coll ready", 32'(cpu_mem_ready), 1);
    chk("coll fault", 32'(bus_fault), 1);
    chk("coll fault_addr", 32'(fault_address), 32'h7FFFC);
    @(negedge clk); bus_fault_ack = 1'b1;
    @(negedge clk); bus_fault_ack = 1'b0;
    chk("coll ack_clear", 32'(bus_fault), 0);

    // Reset mid-wait on a DSP access.
    @(negedge clk); cpu_mem_valid = 1'b1; cpu_address = 20'h30000;
    @(negedge clk); @(negedge clk);
    chk("rmw busy", 32'(busy), 1);
    reset = 1'b1;
    @(negedge clk);
    chk("rmw outputs", {cpu_mem_ready, busy, bus_fault, fault_address}, 0);
    reset = 1'b0; cpu_mem_valid = 1'b0;
    seen = 0;
    repeat (6) begin @(negedge clk); if (cpu_mem_ready || busy) seen = 1; end
    chk("rmw no_ready", 32'(seen), 0);
    access(vecs[0], 100);

    // Valid dropped during WAIT: abandon quietly.
    @(negedge clk); cpu_mem_valid = 1'b1; cpu_address = 20'h30004;
    @(negedge clk); @(negedge clk); cpu_mem_valid = 1'b0;
    @(negedge clk);
    chk("drop busy", 32'(busy), 0);
    seen = 0;
    repeat (6) begin @(negedge clk); if (cpu_mem_ready) seen = 1; end
    chk("drop no_ready", 32'(seen), 0);
    chk("drop no_fault", 32'(bus_fault), 0);

    // Valid held high: two RAM accesses spaced two cycles apart.
    @(negedge clk); cpu_mem_valid = 1'b1; cpu_address = 20'h00010;
    for (int i = 2; i >= 0; i--) begin @(negedge clk); pat[i] = cpu_mem_ready; end
    cpu_mem_valid = 1'b0;
    chk("b2b pattern", 32'(pat), 32'b101);
    @(negedge clk);
    chk("b2b idle", {busy, cpu_mem_ready}, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
